adam_axil_mem_slv: RTL and testbench

- AXI-Lite responder that terminates one hsdom/lsdom memory port of the fabric and drives a single-port, byte-enabled synchronous SRAM macro.
- Implements the slave end of the ADAM_PAUSE req/ack handshake, so syscfg can quiesce the memory before changing its clock or power state.
- Sits between the fabric memory master port and the technology SRAM; one instance per memory bank.

---
 rtl/adam_axil_mem_pkg.sv | 19 +
 rtl/adam_axil_mem_slv.sv | 150 +++++++++++++++
 tb/tb_adam_axil_mem_slv.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adam_axil_mem_pkg.sv
// Shared types for the AXI-Lite memory responder.
package adam_axil_mem_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEM,
    WR_RESP,
    RD_MEM,
    RD_CAP,
    RD_RESP,
    PAUSED
  } state_t;

endpackage

// File: rtl/adam_axil_mem_slv.sv
// AXI-Lite responder driving one single-port byte-enabled SRAM bank.
// One transaction in flight at a time; reads/writes round-robin arbitrated.
// The ADAM_PAUSE slave handshake parks the FSM in PAUSED between transactions.
module adam_axil_mem_slv
  import adam_axil_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 4096,
  parameter int MEM_AW     = $clog2(MEM_SIZE / (DATA_WIDTH / 8))
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pause_req,
  output logic                    pause_ack,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int                  BW  = DATA_WIDTH / 8;
  localparam int                  OFF = $clog2(BW);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);

  state_t                  r_state, w_nxt;
  logic                    r_rr_wr_last;
  logic [MEM_AW-1:0]       r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [BW-1:0]           r_be;
  logic                    r_inr;
  resp_t                   r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_wr_elig, w_rd_elig, w_wr_gnt, w_rd_gnt;
  logic                    w_wr_go, w_rd_go, w_oor;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;

  // Round-robin: on contention serve the class not served last.
  assign w_wr_elig  = aw_valid && w_valid;
  assign w_rd_elig  = ar_valid;
  assign w_wr_gnt   = w_wr_elig && (!w_rd_elig || !r_rr_wr_last);
  assign w_rd_gnt   = w_rd_elig && (!w_wr_elig ||  r_rr_wr_last);

  assign w_sel_addr = w_rd_go ? ar_addr : aw_addr;
  assign w_oor      = {1'b0, w_sel_addr} >= LIM;

  // A pending pause in IDLE must win over grants, otherwise an accepted
  // request would be stranded by the jump to PAUSED; so readys are gated here.
  assign aw_ready  = w_wr_go;
  assign w_ready   = w_wr_go;
  assign ar_ready  = w_rd_go;

  assign b_valid   = (r_state == WR_RESP);
  assign r_valid   = (r_state == RD_RESP);
  assign b_resp    = r_bresp;
  assign r_resp    = r_rresp;
  assign r_data    = r_rdata;
  assign pause_ack = (r_state == PAUSED);

  assign mem_req   = ((r_state == WR_MEM) || (r_state == RD_MEM)) && r_inr;
  assign mem_we    = (r_state == WR_MEM);
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PAUSED;
    else        r_state <= w_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_nxt   = r_state;
    w_wr_go = 1'b0;
    w_rd_go = 1'b0;
    case (r_state)
      IDLE: begin
        if (pause_req) begin
          w_nxt = PAUSED;
        end else if (w_wr_gnt) begin
          w_wr_go = 1'b1;
          w_nxt   = WR_MEM;
        end else if (w_rd_gnt) begin
          w_rd_go = 1'b1;
          w_nxt   = RD_MEM;
        end
      end
      WR_MEM:  w_nxt = WR_RESP;
      WR_RESP: if (b_ready) w_nxt = IDLE;
      RD_MEM:  w_nxt = RD_CAP;
      RD_CAP:  w_nxt = RD_RESP;
      RD_RESP: if (r_ready) w_nxt = IDLE;
      PAUSED:  if (!pause_req) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Request capture at handshake and read-data capture in RD_CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_wr_last <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_inr        <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_rresp      <= RESP_OKAY;
      r_rdata      <= '0;
    end else begin
      if (w_wr_go) begin
        r_rr_wr_last <= 1'b1;
        r_addr       <= w_sel_addr[MEM_AW+OFF-1:OFF];
        r_wdata      <= w_data;
        r_be         <= w_strb;
        r_inr        <= !w_oor;
        r_bresp      <= w_oor ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_rd_go) begin
        r_rr_wr_last <= 1'b0;
        r_addr       <= w_sel_addr[MEM_AW+OFF-1:OFF];
        r_be         <= '0;
        r_inr        <= !w_oor;
        r_rresp      <= w_oor ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_state == RD_CAP) r_rdata <= r_inr ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_adam_axil_mem_slv.sv
// Scoreboard bench for adam_axil_mem_slv with a behavioural SRAM bank.
module tb_adam_axil_mem_slv;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MS  = 4096;
  localparam int MAW = 10;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  rsp;
  } rexp_t;

  logic           clk, rst_n, pause_req, pause_ack;
  logic [AW-1:0]  aw_addr, ar_addr;
  logic           aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic           ar_valid, ar_ready, r_valid, r_ready;
  logic [DW-1:0]  w_data, r_data, mem_wdata, mem_rdata;
  logic [3:0]     w_strb, mem_be;
  logic [1:0]     b_resp, r_resp;
  logic           mem_req, mem_we;
  logic [MAW-1:0] mem_addr;

  logic [31:0]    sram [0:1023];
  logic [7:0]     mdl  [0:MS-1];
  logic           clr;
  int             mreq_cnt;
  int             n_tot, n_bad;
  logic [1:0]     bq[$];
  rexp_t          rq[$];

  adam_axil_mem_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(posedge clk) if (mem_req) mreq_cnt <= mreq_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic rexp_t exp_word(input logic [31:0] a);
    rexp_t e;
    int    b;
    if (a >= MS) begin
      e.d = '0; e.rsp = 2'b10;
    end else begin
      b = int'(a[11:2]) * 4;
      e.d = {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
      e.rsp = 2'b00;
    end
    return e;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int b;
    if (a < MS) begin
      b = int'(a[11:2]) * 4;
      for (int k = 0; k < 4; k++) if (s[k]) mdl[b+k] = d[8*k +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int   n, lat;
    logic inr;
    @(negedge clk);
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1; w_valid = 1; b_ready = 1;
    #1;
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      chk("aw_timeout", 0, 1);
      aw_valid = 0; w_valid = 0;
      return;
    end
    inr = (a < MS);
    bq.push_back(inr ? 2'b00 : 2'b10);
    mdl_write(a, d, s);
    @(posedge clk); #1;
    aw_valid = 0; w_valid = 0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        chk("wr_mreq", {63'd0, mem_req}, {63'd0, inr});
        chk("wr_we", {63'd0, mem_we}, 64'd1);
        if (inr) chk("wr_be", {60'd0, mem_be}, {60'd0, s});
      end
    end while (!b_valid && lat < 20);
    chk("wr_lat", lat, 2);
    if (bq.size() > 0) chk("wr_bresp", {62'd0, b_resp}, {62'd0, bq.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    int    n, lat;
    logic  inr;
    rexp_t e;
    @(negedge clk);
    ar_addr = a; ar_valid = 1; r_ready = 1;
    #1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      chk("ar_timeout", 0, 1);
      ar_valid = 0;
      return;
    end
    inr = (a < MS);
    rq.push_back(exp_word(a));
    @(posedge clk); #1;
    ar_valid = 0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        chk("rd_mreq", {63'd0, mem_req}, {63'd0, inr});
        chk("rd_we", {63'd0, mem_we}, 64'd0);
      end
    end while (!r_valid && lat < 20);
    chk("rd_lat", lat, 3);
    if (rq.size() > 0) begin
      e = rq.pop_front();
      chk("rd_data", {32'd0, r_data}, {32'd0, e.d});
      chk("rd_resp", {62'd0, r_resp}, {62'd0, e.rsp});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int    g, n, lat, m0;
    logic [3:0] ord;
    logic  chg;
    rexp_t e;

    n_tot = 0; n_bad = 0; mreq_cnt = 0; clr = 1;
    rst_n = 0; pause_req = 1;
    aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
    aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 0; r_ready = 0;
    for (int i = 0; i < MS; i++) mdl[i] = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    clr = 0;
    chk("rst_ack", {63'd0, pause_ack}, 64'd1);
    chk("rst_rdy", {61'd0, aw_ready, w_ready, ar_ready}, 64'd0);
    chk("rst_vld", {61'd0, b_valid, r_valid, mem_req}, 64'd0);
    chk("rst_resp", {60'd0, b_resp, r_resp}, 64'd0);
    chk("rst_rdata", {32'd0, r_data}, 64'd0);
    chk("rst_mem", {17'd0, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);

    // Release with pause held: stays paused, nothing accepted.
    rst_n = 1; aw_valid = 1; w_valid = 1; ar_valid = 1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("pz_ack", {63'd0, pause_ack}, 64'd1);
      chk("pz_rdy", {61'd0, aw_ready, w_ready, ar_ready}, 64'd0);
    end
    aw_valid = 0; w_valid = 0; ar_valid = 0; pause_req = 0;
    #1 chk("unpz_ack_hold", {63'd0, pause_ack}, 64'd1);
    @(negedge clk);
    chk("unpz_ack", {63'd0, pause_ack}, 64'd0);

    // Byte-strobed write then read back; unaligned and boundary addresses.
    do_write(32'h10, 32'hDEAD_BEEF, 4'b0101);
    do_read(32'h10);
    do_write(32'h14, 32'h1234_5678, 4'b1111);
    do_write(32'h16, 32'hAABB_CCDD, 4'b1000);
    do_read(32'h14);
    do_write(32'hFFC, 32'hCAFE_F00D, 4'b1111);
    do_read(32'hFFF);

    // Out-of-range accesses: SLVERR, zero data, no SRAM strobe.
    m0 = mreq_cnt;
    do_write(32'h1000, 32'h5555_5555, 4'b1111);
    do_read(32'h1000);
    do_read(32'hFFFF_FFFC);
    chk("oor_no_mreq", mreq_cnt, m0);
    do_read(32'h0);

    // Continuous AW+W and AR from reset: grants alternate, read first.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    aw_addr = 32'h40; ar_addr = 32'h40; w_data = 32'h0101_0101; w_strb = 4'hF;
    aw_valid = 1; w_valid = 1; ar_valid = 1; b_ready = 1; r_ready = 1;
    g = 0; ord = '0; chg = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (g >= 4 && bq.size() == 0 && rq.size() == 0) break;
      if (chg) begin w_data = w_data + 32'h1111_1111; chg = 0; end
      if (g >= 4) begin aw_valid = 0; w_valid = 0; ar_valid = 0; end
      #1;
      if (r_valid && rq.size() > 0) begin
        e = rq.pop_front();
        chk("cc_rdata", {32'd0, r_data}, {32'd0, e.d});
      end
      if (b_valid && bq.size() > 0)
        chk("cc_bresp", {62'd0, b_resp}, {62'd0, bq.pop_front()});
      if (ar_ready && g < 4) begin
        ord = {ord[2:0], 1'b0}; g++;
        rq.push_back(exp_word(32'h40));
      end
      if (aw_ready && g < 4) begin
        ord = {ord[2:0], 1'b1}; g++;
        mdl_write(32'h40, w_data, 4'hF);
        bq.push_back(2'b00);
        chg = 1;
      end
    end
    chk("cc_grants", g, 4);
    chk("cc_order", {60'd0, ord}, 64'b0101);
    chk("cc_drain", bq.size() + rq.size(), 0);
    aw_valid = 0; w_valid = 0; ar_valid = 0;

    // Pause raised mid-read with a stalled R channel.
    @(negedge clk);
    r_ready = 0; ar_addr = 32'h14; ar_valid = 1;
    #1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("pr_ar_acc", {63'd0, ar_ready}, 64'd1);
    rq.push_back(exp_word(32'h14));
    @(posedge clk); #1;
    pause_req = 1; ar_addr = 32'h10;
    lat = 1;
    @(negedge clk);
    while (!r_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("pr_lat", lat, 3);
    e = (rq.size() > 0) ? rq.pop_front() : '0;
    repeat (5) begin
      chk("pr_hold_vld", {63'd0, r_valid}, 64'd1);
      chk("pr_hold_data", {32'd0, r_data}, {32'd0, e.d});
      @(negedge clk);
    end
    r_ready = 1;
    @(negedge clk); #1;
    chk("pr_ack_h1", {63'd0, pause_ack}, 64'd0);
    chk("pr_no_ar_h1", {63'd0, ar_ready}, 64'd0);
    @(negedge clk); #1;
    chk("pr_ack_h2", {63'd0, pause_ack}, 64'd1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("pr_no_ar", {63'd0, ar_ready}, 64'd0);
    end
    ar_valid = 0; pause_req = 0;
    repeat (2) @(negedge clk);
    chk("pr_unpz", {63'd0, pause_ack}, 64'd0);

    // Reset asserted while the write response is stalled.
    @(negedge clk);
    b_ready = 0; aw_addr = 32'h20; w_data = 32'h7654_3210; w_strb = 4'hF;
    aw_valid = 1; w_valid = 1;
    #1;
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("rr_aw_acc", {63'd0, aw_ready}, 64'd1);
    mdl_write(32'h20, 32'h7654_3210, 4'hF);
    @(posedge clk); #1;
    aw_valid = 0; w_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_valid && n < 20);
    chk("rr_bvld_pre", {63'd0, b_valid}, 64'd1);
    #1 rst_n = 0;
    #1;
    chk("rr_bvld_async", {63'd0, b_valid}, 64'd0);
    chk("rr_ack_async", {63'd0, pause_ack}, 64'd1);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rr_ack_rel", {63'd0, pause_ack}, 64'd1);
    chk("rr_bvld_rel", {63'd0, b_valid}, 64'd0);
    do_read(32'h20);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
